// File: rtl/uart_receiver_core_if.sv
// Register-block side of the UART receive path: line control, FIFO access and
// status/counter readback.
interface uart_receiver_core_if;
    logic [7:0] lcr;
    logic       rf_pop;
    logic       enable;
    logic       rda_int;
    logic       rx_reset;
    logic       rx_lsr_mask;
    logic [5:0] counter_t;
    logic [3:0] counter_b;
    logic [4:0] rf_count;
    logic [9:0] rf_data_out;
    logic       rf_error_bit;
    logic       rf_overrun;

    modport master (
        output lcr, rf_pop, enable, rda_int, rx_reset, rx_lsr_mask,
        input  counter_t, counter_b, rf_count, rf_data_out, rf_error_bit, rf_overrun
    );
    modport slave (
        input  lcr, rf_pop, enable, rda_int, rx_reset, rx_lsr_mask,
        output counter_t, counter_b, rf_count, rf_data_out, rf_error_bit, rf_overrun
    );
endinterface

// File: rtl/uart_receiver_core.sv
// 16550-style serial receiver: 16x oversampled deframer feeding a 16-entry
// record FIFO, plus break and character-timeout counters.
module uart_receiver_core (
    input  logic                 clk,
    input  logic                 wb_rst_i,
    input  logic                 srx_pad_i,
    uart_receiver_core_if.slave  rif
);
    localparam int FIFO_DEPTH = 16;
    localparam int REC_WIDTH  = 10;
    localparam int COUNTER_W  = 5;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH} state_t;

    state_t               state_q, state_d;
    logic                 srx_s1, srx;
    logic [3:0]           tick_q;
    logic [2:0]           bit_q;
    logic [7:0]           data_q;
    logic                 pe_q, fe_q, armed_q;
    logic                 mid, push, par_exp;
    logic [3:0]           len, frame_bits;
    logic [REC_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wptr, rptr;
    logic [COUNTER_W-1:0] count;
    logic                 do_pop, do_push, full, err;
    logic [3:0]           brk_div, tmo_div;
    logic                 unused_ok;

    assign unused_ok  = ^{rif.rda_int, rif.lcr[7:6]};
    assign len        = 4'd5 + {2'b00, rif.lcr[1:0]};
    assign frame_bits = 4'd2 + len + {3'b000, rif.lcr[3]};
    assign par_exp    = rif.lcr[5] ? ~rif.lcr[4] : (rif.lcr[4] ? ^data_q : ~^data_q);

    always_ff @(posedge clk or posedge wb_rst_i)
        if (wb_rst_i) begin
            srx_s1 <= 1'b1;
            srx    <= 1'b1;
        end else begin
            srx_s1 <= srx_pad_i;
            srx    <= srx_s1;
        end

    always_ff @(posedge clk or posedge wb_rst_i)
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_d;

    // Start bit is re-checked half a bit in; every later sample is a full bit apart.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        mid     = rif.enable && ((state_q == S_START) ? (tick_q == 4'd7) : (tick_q == 4'd15));
        case (state_q)
            S_IDLE:   if (rif.enable && !srx && armed_q) state_d = S_START;
            S_START:  if (mid) state_d = srx ? S_IDLE : S_DATA;
            S_DATA:   if (mid && ({1'b0, bit_q} == len - 4'd1))
                          state_d = rif.lcr[3] ? S_PARITY : S_STOP;
            S_PARITY: if (mid) state_d = S_STOP;
            S_STOP:   if (mid) state_d = S_PUSH;
            S_PUSH: begin
                push    = 1'b1;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
        if (rif.rx_reset) state_d = S_IDLE;
    end

    // armed_q blocks a held-low line (break) from retriggering until it returns high.
    always_ff @(posedge clk or posedge wb_rst_i)
        if (wb_rst_i) begin
            tick_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            if (state_q != state_d) tick_q <= '0;
            else if (rif.enable)    tick_q <= tick_q + 4'd1;
            if (state_q == S_IDLE && state_d == S_START) begin
                data_q <= '0;
                bit_q  <= '0;
                pe_q   <= 1'b0;
                fe_q   <= 1'b0;
            end
            if (mid && state_q == S_DATA) begin
                data_q[bit_q] <= srx;
                bit_q         <= bit_q + 3'd1;
            end
            if (mid && state_q == S_PARITY) pe_q <= srx ^ par_exp;
            if (mid && state_q == S_STOP)   fe_q <= ~srx;
            if (rif.rx_reset || state_q == S_PUSH)           armed_q <= 1'b0;
            else if (state_q == S_IDLE && rif.enable && srx) armed_q <= 1'b1;
        end

    assign full    = (count == COUNTER_W'(FIFO_DEPTH));
    assign do_pop  = rif.rf_pop && (count != '0) && !rif.rx_reset;
    assign do_push = push && (!full || do_pop) && !rif.rx_reset;

    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= {data_q, pe_q, fe_q};

    always_ff @(posedge clk or posedge wb_rst_i)
        if (wb_rst_i) begin
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            rif.rf_overrun <= 1'b0;
        end else if (rif.rx_reset) begin
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            rif.rf_overrun <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            count <= count + COUNTER_W'(do_push) - COUNTER_W'(do_pop);
            if (push && !do_push)     rif.rf_overrun <= 1'b1;
            else if (rif.rx_lsr_mask) rif.rf_overrun <= 1'b0;
        end

    always_comb begin
        err = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++)
            if (COUNTER_W'(k) < count) err = err | (|mem[rptr + PTR_W'(k)][1:0]);
    end

    assign rif.rf_count     = count;
    assign rif.rf_error_bit = err;
    assign rif.rf_data_out  = (count == '0) ? '0 : mem[rptr];

    always_ff @(posedge clk or posedge wb_rst_i)
        if (wb_rst_i) begin
            rif.counter_b <= 4'd11;
            brk_div       <= '0;
        end else if (srx) begin
            rif.counter_b <= frame_bits;
            brk_div       <= '0;
        end else if (rif.enable) begin
            brk_div <= brk_div + 4'd1;
            if (brk_div == 4'd15 && rif.counter_b != '0) rif.counter_b <= rif.counter_b - 4'd1;
        end

    // Timeout restarts on any FIFO activity or while empty; counts bit times otherwise.
    always_ff @(posedge clk or posedge wb_rst_i)
        if (wb_rst_i) begin
            rif.counter_t <= 6'd40;
            tmo_div       <= '0;
        end else if (count == '0 || push || rif.rf_pop) begin
            rif.counter_t <= {frame_bits, 2'b00};
            tmo_div       <= '0;
        end else if (rif.enable) begin
            tmo_div <= tmo_div + 4'd1;
            if (tmo_div == 4'd15 && rif.counter_t != '0) rif.counter_t <= rif.counter_t - 6'd1;
        end
endmodule

// File: tb/tb_uart_receiver_core.sv
// Random-character bench for uart_receiver_core: a queue of expected records
// built from the line framing rules is compared against the receive FIFO.
module tb_uart_receiver_core;
    logic clk = 1'b0;
    logic wb_rst_i = 1'b1;
    logic srx_pad_i = 1'b1;
    uart_receiver_core_if rif();

    uart_receiver_core dut (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .srx_pad_i (srx_pad_i),
        .rif       (rif)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    logic [9:0] mq[$];
    logic       exp_ovr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        srx_pad_i = b;
        step(16);
    endtask

    function automatic logic exp_err();
        logic e = 1'b0;
        foreach (mq[i]) e |= |mq[i][1:0];
        return e;
    endfunction

    // Frame one character on the line and record what the FIFO should hold.
    task automatic send_char(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        int         n;
        logic [7:0] m;
        logic       pb, pen;
        n   = 5 + int'(rif.lcr[1:0]);
        m   = d & (8'hFF >> (8 - n));
        pen = rif.lcr[3];
        if (rif.lcr[5])      pb = ~rif.lcr[4];
        else if (rif.lcr[4]) pb = ^m;
        else                 pb = ~^m;
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(m[i]);
        if (pen) send_bit(pb ^ bad_par);
        send_bit(~bad_stop);
        srx_pad_i = 1'b1;
        step(20);
        if (mq.size() == 16) exp_ovr = 1'b1;
        else                 mq.push_back({m, pen & bad_par, bad_stop});
    endtask

    task automatic pop_chk(input string tag);
        chk(tag, 32'(rif.rf_data_out), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
        rif.rf_pop = 1'b1;
        step(1);
        rif.rf_pop = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        step(1);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"}, 32'(rif.rf_count), 32'(mq.size()));
        chk({tag, "_err"},   32'(rif.rf_error_bit), 32'(exp_err()));
        chk({tag, "_ovr"},   32'(rif.rf_overrun), 32'(exp_ovr));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rif.lcr = 8'h03; rif.rf_pop = 0; rif.enable = 1; rif.rda_int = 0;
        rif.rx_reset = 0; rif.rx_lsr_mask = 0;
        step(3);
        chk("rst_count", 32'(rif.rf_count), 0);
        chk("rst_data",  32'(rif.rf_data_out), 0);
        chk("rst_ovr",   32'(rif.rf_overrun), 0);
        chk("rst_err",   32'(rif.rf_error_bit), 0);
        chk("rst_cb",    32'(rif.counter_b), 11);
        chk("rst_ct",    32'(rif.counter_t), 40);
        wb_rst_i = 1'b0;
        step(5);

        // 8N1 0x55
        send_char(8'h55, 0, 0);
        chk("c55_count", 32'(rif.rf_count), 1);
        chk("c55_data",  32'(rif.rf_data_out), 32'h154);
        chk("c55_err",   32'(rif.rf_error_bit), 0);
        pop_chk("c55_pop");
        chk_state("c55_after");

        // even parity, bad parity bit
        rif.lcr = 8'h1B;
        send_char(8'hA5, 1, 0);
        chk("par_data", 32'(rif.rf_data_out), 32'h296);
        chk("par_err",  32'(rif.rf_error_bit), 1);
        pop_chk("par_pop");
        chk("par_count", 32'(rif.rf_count), 0);

        // short start glitch
        rif.lcr = 8'h03;
        srx_pad_i = 1'b0; step(4); srx_pad_i = 1'b1; step(300);
        chk("glitch_count", 32'(rif.rf_count), 0);

        // character timeout
        send_char(8'h3C, 0, 0);
        step(600);
        chk("tmo_running", 32'(rif.counter_t != 0), 1);
        step(50);
        chk("tmo_zero", 32'(rif.counter_t), 0);
        pop_chk("tmo_pop");
        chk("tmo_reload", 32'(rif.counter_t), 40);

        // overrun
        for (int i = 0; i < 17; i++) send_char(8'($urandom), 0, 0);
        chk("ovr_count", 32'(rif.rf_count), 16);
        chk("ovr_flag",  32'(rif.rf_overrun), 1);
        rif.rx_lsr_mask = 1'b1; step(1); rif.rx_lsr_mask = 1'b0; step(1);
        exp_ovr = 1'b0;
        chk("ovr_clr",    32'(rif.rf_overrun), 0);
        chk("ovr_count2", 32'(rif.rf_count), 16);
        for (int i = 0; i < 16; i++) pop_chk("ovr_drain");
        chk_state("ovr_empty");

        // break: line held low 12 bit times
        srx_pad_i = 1'b0;
        step(12 * 16);
        mq.push_back(10'h001);
        chk("brk_count", 32'(rif.rf_count), 1);
        chk("brk_data",  32'(rif.rf_data_out), 32'h001);
        chk("brk_cb",    32'(rif.counter_b), 0);
        step(5 * 16);
        chk("brk_norepeat", 32'(rif.rf_count), 1);
        srx_pad_i = 1'b1;
        step(20);
        chk("brk_cb_reload", 32'(rif.counter_b), 10);
        pop_chk("brk_pop");

        // rx_reset flush
        for (int i = 0; i < 5; i++) send_char(8'($urandom), 0, i == 2);
        chk("rxr_count5", 32'(rif.rf_count), 5);
        rif.rx_reset = 1'b1; step(1); rif.rx_reset = 1'b0; step(1);
        mq.delete();
        exp_ovr = 1'b0;
        chk("rxr_count", 32'(rif.rf_count), 0);
        chk("rxr_data",  32'(rif.rf_data_out), 0);
        chk_state("rxr");

        // random formats, errors and pops
        for (int i = 0; i < 40; i++) begin
            rif.lcr = 8'($urandom_range(0, 63));
            send_char(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            chk_state("rnd");
            if (mq.size() != 0 && $urandom_range(0, 1) == 1) pop_chk("rnd_pop");
        end
        while (mq.size() != 0) pop_chk("rnd_drain");
        chk_state("rnd_end");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
